// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction-memory loader.
package riscv_pkg;

  localparam int unsigned INSTR_W = 32;

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StData,
    StWrite,
    StDone,
    StErr
  } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Host byte link plus imem write port and load status, bundled for the loader.
interface imem_loader_if #(
  parameter int unsigned AW = 5
) ();

  logic                        start;
  logic [7:0]                  rx_data;
  logic                        rx_valid;
  logic                        rx_ready;
  logic                        we;
  logic [AW-1:0]               waddr;
  logic [riscv_pkg::INSTR_W-1:0] wdata;
  logic                        busy;
  logic                        done;
  logic                        err;

  // Host / imem side.
  modport master (
    output start, rx_data, rx_valid,
    input  rx_ready, we, waddr, wdata, busy, done, err
  );

  // Loader side.
  modport slave (
    input  start, rx_data, rx_valid,
    output rx_ready, we, waddr, wdata, busy, done, err
  );

endinterface

// File: rtl/imem_loader_word_assembler.sv
// Packs bytes little-endian into a 32-bit word; word_o is the word including the
// byte being loaded this cycle so the caller can register it on the same edge.
module imem_loader_word_assembler
  import riscv_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               clear_i,
  input  logic               load_i,
  input  logic [7:0]         byte_i,
  output logic [INSTR_W-1:0] word_o,
  output logic               word_ready_o
);

  logic [INSTR_W-1:0] word_q, word_d;
  logic [1:0]         idx_q, idx_d;

  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (clear_i) begin
      idx_d = 2'd0;
    end else if (load_i) begin
      word_d[{idx_q, 3'b000} +: 8] = byte_i;
      idx_d                        = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      word_q <= '0;
      idx_q  <= 2'd0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

  assign word_o       = word_d;
  assign word_ready_o = load_i && !clear_i && (idx_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into imem as 32-bit words from address 0,
// holding the core via busy until the load finishes or aborts.
module imem_loader
  import riscv_pkg::*;
#(
  parameter int unsigned n  = 32,
  parameter int unsigned AW = 5
) (
  input  logic         clock,
  input  logic         reset,
  imem_loader_if.slave bus
);

  localparam int unsigned MaxW = 1 << AW;

  loader_state_t state_q, state_d;
  logic [AW-1:0] last_q, last_d;
  logic [AW-1:0] word_idx_q, word_idx_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [n-1:0]  wdata_q, wdata_d;
  logic          rx_ready_q, rx_ready_d;
  logic          we_q, we_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic               xfer;
  logic               asm_clear;
  logic               asm_load;
  logic [INSTR_W-1:0] asm_word;
  logic               asm_ready;

  // rx_ready is a flop, so acceptance never depends combinationally on rx_valid.
  assign xfer = bus.rx_valid && rx_ready_q;

  imem_loader_word_assembler u_asm (
    .clock        (clock),
    .reset        (reset),
    .clear_i      (asm_clear),
    .load_i       (asm_load),
    .byte_i       (bus.rx_data),
    .word_o       (asm_word),
    .word_ready_o (asm_ready)
  );

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    word_idx_d = word_idx_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    done_d     = done_q;
    err_d      = err_q;
    asm_clear  = 1'b0;
    asm_load   = 1'b0;

    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (bus.start) begin
          state_d    = StLen;
          done_d     = 1'b0;
          err_d      = 1'b0;
          waddr_d    = '0;
          word_idx_d = '0;
          asm_clear  = 1'b1;
        end
      end
      StLen: begin
        if (xfer) begin
          if ((bus.rx_data == 8'd0) || (32'(bus.rx_data) > MaxW)) begin
            state_d = StErr;
            err_d   = 1'b1;
          end else begin
            last_d  = AW'(bus.rx_data - 8'd1);
            state_d = StData;
          end
        end
      end
      StData: begin
        asm_load = xfer;
        if (asm_ready) begin
          state_d = StWrite;
          wdata_d = asm_word;
          waddr_d = word_idx_q;
        end
      end
      StWrite: begin
        if (word_idx_q == last_q) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          word_idx_d = word_idx_q + 1'b1;
          state_d    = StData;
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered from the next state so they line up with it.
    rx_ready_d = (state_d == StLen) || (state_d == StData);
    we_d       = (state_d == StWrite);
    busy_d     = (state_d == StLen) || (state_d == StData) || (state_d == StWrite);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      last_q     <= '0;
      word_idx_q <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      rx_ready_q <= 1'b0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      word_idx_q <= word_idx_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      rx_ready_q <= rx_ready_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.rx_ready = rx_ready_q;
  assign bus.we       = we_q;
  assign bus.waddr    = waddr_q;
  assign bus.wdata    = wdata_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal loads, bad counts, gaps, reset and stray start.
module tb_imem_loader;

  localparam int unsigned AW = 5;

  logic clock = 1'b0;
  logic reset;

  imem_loader_if #(.AW(AW)) bus ();

  imem_loader #(
    .n  (32),
    .AW (AW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int xfers = 0;

  logic [AW-1:0] log_a[$];
  logic [31:0]   log_d[$];

  always #5 clock = ~clock;

  // we is high for a full cycle, so each pulse is seen at exactly one negedge.
  always @(negedge clock) begin
    if (bus.we === 1'b1) begin
      log_a.push_back(bus.waddr);
      log_d.push_back(bus.wdata);
    end
  end

  always @(posedge clock) begin
    if (bus.rx_valid && bus.rx_ready) xfers++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // All tasks are entered and left at a negedge.
  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int w = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (bus.rx_ready !== 1'b1 && w < 20) begin
      @(negedge clock);
      w++;
    end
    n_cmp++;
    if (bus.rx_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL send_byte_ready: rx_ready=%b after %0d cycles, required 1", bus.rx_ready, w);
    end
    @(negedge clock);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic clear_log();
    log_a.delete();
    log_d.delete();
  endtask

  task automatic test_reset();
    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    #1 reset = 1'b1;
    #2;
    n_cmp++;
    if ({bus.rx_ready, bus.we, bus.busy, bus.done, bus.err} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_flags: rx_ready/we/busy/done/err=%b required 00000",
               {bus.rx_ready, bus.we, bus.busy, bus.done, bus.err});
    end
    n_cmp++;
    if (bus.waddr !== '0 || bus.wdata !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_bus: waddr=%h wdata=%h required 0/0", bus.waddr, bus.wdata);
    end
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    n_cmp++;
    if (bus.rx_ready !== 1'b0 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_ready: rx_ready=%b busy=%b required 0/0", bus.rx_ready, bus.busy);
    end
  endtask

  task automatic test_two_words();
    clear_log();
    pulse_start();
    n_cmp++;
    if (bus.busy !== 1'b1 || bus.rx_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL two_len_state: busy=%b rx_ready=%b required 1/1", bus.busy, bus.rx_ready);
    end
    send_byte(8'h02);
    send_word(32'h0000_0013);
    n_cmp++;
    if (bus.we !== 1'b1 || bus.waddr !== 5'd0 || bus.wdata !== 32'h0000_0013) begin
      n_bad++;
      $display("FAIL two_we0_latency: we=%b waddr=%0d wdata=%h required 1/0/00000013",
               bus.we, bus.waddr, bus.wdata);
    end
    send_word(32'h0010_0093);
    n_cmp++;
    if (bus.we !== 1'b1 || bus.done !== 1'b0) begin
      n_bad++;
      $display("FAIL two_we1_latency: we=%b done=%b required 1/0", bus.we, bus.done);
    end
    @(negedge clock);
    n_cmp++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.err !== 1'b0 || bus.we !== 1'b0) begin
      n_bad++;
      $display("FAIL two_done: done=%b busy=%b err=%b we=%b required 1/0/0/0",
               bus.done, bus.busy, bus.err, bus.we);
    end
    repeat (3) @(negedge clock);
    n_cmp++;
    if (log_a.size() != 2) begin
      n_bad++;
      $display("FAIL two_count: writes=%0d required 2", log_a.size());
    end else begin
      if (log_a[0] !== 5'd0 || log_d[0] !== 32'h0000_0013) begin
        n_bad++;
        $display("FAIL two_word0: waddr=%0d wdata=%h required 0/00000013", log_a[0], log_d[0]);
      end
      n_cmp++;
      if (log_a[1] !== 5'd1 || log_d[1] !== 32'h0010_0093) begin
        n_bad++;
        $display("FAIL two_word1: waddr=%0d wdata=%h required 1/00100093", log_a[1], log_d[1]);
      end
    end
    n_cmp++;
    if (bus.waddr !== 5'd1 || bus.wdata !== 32'h0010_0093 || bus.done !== 1'b1) begin
      n_bad++;
      $display("FAIL two_hold: waddr=%0d wdata=%h done=%b required 1/00100093/1",
               bus.waddr, bus.wdata, bus.done);
    end
  endtask

  task automatic test_count_zero();
    clear_log();
    pulse_start();
    send_byte(8'h00);
    repeat (3) @(negedge clock);
    n_cmp++;
    if (bus.err !== 1'b1 || bus.done !== 1'b0 || bus.busy !== 1'b0 || log_a.size() != 0) begin
      n_bad++;
      $display("FAIL zero_err: err=%b done=%b busy=%b writes=%0d required 1/0/0/0",
               bus.err, bus.done, bus.busy, log_a.size());
    end
    pulse_start();
    n_cmp++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL zero_restart: err=%b busy=%b required 0/1", bus.err, bus.busy);
    end
    send_byte(8'h01);
    send_word(32'hDEAD_BEEF);
    @(negedge clock);
    n_cmp++;
    if (bus.done !== 1'b1 || bus.err !== 1'b0 || log_a.size() != 1) begin
      n_bad++;
      $display("FAIL zero_reload: done=%b err=%b writes=%0d required 1/0/1",
               bus.done, bus.err, log_a.size());
    end else begin
      n_cmp++;
      if (log_a[0] !== 5'd0 || log_d[0] !== 32'hDEAD_BEEF) begin
        n_bad++;
        $display("FAIL zero_reload_word: waddr=%0d wdata=%h required 0/deadbeef",
                 log_a[0], log_d[0]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] w;
    clear_log();
    pulse_start();
    send_byte(8'h21);
    repeat (3) @(negedge clock);
    n_cmp++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0 || log_a.size() != 0) begin
      n_bad++;
      $display("FAIL ovf_err: err=%b busy=%b writes=%0d required 1/0/0",
               bus.err, bus.busy, log_a.size());
    end
    pulse_start();
    send_byte(8'h20);
    for (int i = 0; i < 32; i++) begin
      w = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
      send_word(w);
    end
    @(negedge clock);
    n_cmp++;
    if (bus.done !== 1'b1 || bus.err !== 1'b0 || log_a.size() != 32) begin
      n_bad++;
      $display("FAIL full_done: done=%b err=%b writes=%0d required 1/0/32",
               bus.done, bus.err, log_a.size());
    end else begin
      for (int i = 0; i < 32; i++) begin
        w = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
        n_cmp++;
        if (log_a[i] !== 5'(i) || log_d[i] !== w) begin
          n_bad++;
          $display("FAIL full_word%0d: waddr=%0d wdata=%h required %0d/%h",
                   i, log_a[i], log_d[i], i, w);
        end
      end
      n_cmp++;
      if (bus.waddr !== 5'd31) begin
        n_bad++;
        $display("FAIL full_last_addr: waddr=%0d required 31", bus.waddr);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] s [9];
    s = '{8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    clear_log();
    pulse_start();
    xfers = 0;
    for (int k = 0; k < 9; k++) begin
      if (k == 5) begin
        // Present the next byte during the WRITE cycle; it must wait.
        bus.rx_data  = s[k];
        bus.rx_valid = 1'b1;
        n_cmp++;
        if (bus.rx_ready !== 1'b0 || bus.we !== 1'b1) begin
          n_bad++;
          $display("FAIL bp_write_ready: rx_ready=%b we=%b required 0/1", bus.rx_ready, bus.we);
        end
        @(negedge clock);
      end
      send_byte(s[k]);
      if (k != 4) repeat ($urandom_range(0, 3)) @(negedge clock);
    end
    repeat (3) @(negedge clock);
    n_cmp++;
    if (xfers != 9) begin
      n_bad++;
      $display("FAIL bp_bytes: transfers=%0d required 9", xfers);
    end
    n_cmp++;
    if (log_a.size() != 2) begin
      n_bad++;
      $display("FAIL bp_count: writes=%0d required 2", log_a.size());
    end else begin
      if (log_a[0] !== 5'd0 || log_d[0] !== 32'h0000_0013 ||
          log_a[1] !== 5'd1 || log_d[1] !== 32'h0010_0093) begin
        n_bad++;
        $display("FAIL bp_words: %0d/%h %0d/%h required 0/00000013 1/00100093",
                 log_a[0], log_d[0], log_a[1], log_d[1]);
      end
    end
    n_cmp++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_done: done=%b busy=%b required 1/0", bus.done, bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    clear_log();
    pulse_start();
    send_byte(8'h02);
    send_word(32'h1122_3344);
    send_byte(8'hAA);
    send_byte(8'hBB);
    #1 reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus.rx_ready, bus.we, bus.busy, bus.done, bus.err} !== 5'b0 ||
        bus.waddr !== '0 || bus.wdata !== 32'h0) begin
      n_bad++;
      $display("FAIL mid_reset_async: flags=%b waddr=%0d wdata=%h required 00000/0/0",
               {bus.rx_ready, bus.we, bus.busy, bus.done, bus.err}, bus.waddr, bus.wdata);
    end
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    n_cmp++;
    if (log_a.size() != 1) begin
      n_bad++;
      $display("FAIL mid_reset_partial: writes=%0d required 1", log_a.size());
    end
    pulse_start();
    send_byte(8'h01);
    send_word(32'h5566_7788);
    n_cmp++;
    if (bus.we !== 1'b1 || bus.waddr !== 5'd0 || bus.wdata !== 32'h5566_7788) begin
      n_bad++;
      $display("FAIL mid_reset_fresh: we=%b waddr=%0d wdata=%h required 1/0/55667788",
               bus.we, bus.waddr, bus.wdata);
    end
    @(negedge clock);
    n_cmp++;
    if (bus.done !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_reset_done: done=%b required 1", bus.done);
    end
  endtask

  task automatic test_start_in_data();
    clear_log();
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h13);
    send_byte(8'h00);
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h00);
    send_word(32'h0010_0093);
    @(negedge clock);
    n_cmp++;
    if (bus.done !== 1'b1 || bus.err !== 1'b0 || log_a.size() != 2) begin
      n_bad++;
      $display("FAIL sdata_done: done=%b err=%b writes=%0d required 1/0/2",
               bus.done, bus.err, log_a.size());
    end else begin
      n_cmp++;
      if (log_a[0] !== 5'd0 || log_d[0] !== 32'h0000_0013 ||
          log_a[1] !== 5'd1 || log_d[1] !== 32'h0010_0093) begin
        n_bad++;
        $display("FAIL sdata_words: %0d/%h %0d/%h required 0/00000013 1/00100093",
                 log_a[0], log_d[0], log_a[1], log_d[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_count_zero();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_start_in_data();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
